// File: rtl/computer_bootable_if.sv
// Control/load/debug port bundle for computer_bootable.
//   slave  : seen by the computer (loads, start/stop, debug address in;
//            status, halt info, cycle count, debug data out)
//   master : seen by whoever drives the computer (bench, host bridge)
interface computer_bootable_if #(
    parameter int IMEM_AW = 15,
    parameter int DMEM_AW = 14,
    parameter int CYCLE_W = 32
);
    logic               load_valid;
    logic               load_ready;
    logic [IMEM_AW-1:0] load_addr;
    logic [15:0]        load_data;
    logic               start;
    logic               stop;
    logic               running;
    logic               halted;
    logic [IMEM_AW-1:0] halt_pc;
    logic [CYCLE_W-1:0] cycle_count;
    logic [DMEM_AW-1:0] dbg_addr;
    logic [15:0]        dbg_data;

    modport slave (
        input  load_valid, load_addr, load_data, start, stop, dbg_addr,
        output load_ready, running, halted, halt_pc, cycle_count, dbg_data
    );

    modport master (
        output load_valid, load_addr, load_data, start, stop, dbg_addr,
        input  load_ready, running, halted, halt_pc, cycle_count, dbg_data
    );
endinterface

// File: rtl/computer_bootable.sv
// Hack computer with writable instruction memory, data RAM and run control.
// Programs are loaded over a valid/ready port while idle or halted, then
// started; execution halts on its own at the "(END) @END; 0;JMP" idiom.
// Ports:
//   clock  : rising-edge system clock
//   reset  : asynchronous active-high, returns run control to IDLE
//   bus    : computer_bootable_if.slave (load port, start/stop, status,
//            halt pc, RUN cycle counter, combinational debug read of RAM)
module computer_bootable #(
    parameter int IMEM_AW        = 15,
    parameter int DMEM_AW        = 14,
    parameter bit CLEAR_ON_START = 1'b1,
    parameter int CYCLE_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    computer_bootable_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic [IMEM_AW-1:0] halt_pc_q, halt_pc_d;
    logic [CYCLE_W-1:0] cyc_q, cyc_d;
    logic [DMEM_AW-1:0] clr_q, clr_d;

    logic [15:0] imem [2**IMEM_AW];
    logic [15:0] dmem [2**DMEM_AW];

    // CPU core state
    logic [15:0] a_q, a_d, d_q, d_d;
    logic [14:0] pc_q, pc_d;

    logic               cpu_rst;
    logic [15:0]        instr;
    logic [15:0]        in_m;
    logic [15:0]        alu_x, alu_y, alu_o;
    logic               is_c, write_m, jump, zr, ng;
    logic [14:0]        addr_m;
    logic               dm_in_range;
    logic [DMEM_AW-1:0] dm_idx;
    logic               halt_hit;
    logic               load_ready;
    logic               load_fire;

    assign cpu_rst     = (state_q != S_RUN);
    assign instr       = imem[pc_q[IMEM_AW-1:0]];
    assign addr_m      = a_q[14:0];
    // Anything above the RAM depth is unmapped: writes dropped, reads zero.
    assign dm_in_range = ((addr_m >> DMEM_AW) == 15'd0);
    assign dm_idx      = addr_m[DMEM_AW-1:0];
    assign in_m        = dm_in_range ? dmem[dm_idx] : 16'h0000;

    // A jump whose target is the preceding word (the @END that loaded it)
    // can never leave the loop, so it marks the end of the program.
    assign halt_hit = instr[15] && (instr[2:0] == 3'b111) && (addr_m == pc_q - 15'd1);

    assign load_ready = (state_q == S_IDLE) || (state_q == S_HALT);
    assign load_fire  = bus.load_valid && load_ready;

    assign bus.load_ready  = load_ready;
    assign bus.running     = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign bus.halted      = halted_q;
    assign bus.halt_pc     = halt_pc_q;
    assign bus.cycle_count = cyc_q;
    assign bus.dbg_data    = dmem[bus.dbg_addr];

    // ---------------- CPU core: ALU, jump and register next-state ----------------
    always_comb begin
        is_c  = instr[15];
        alu_x = d_q;
        alu_y = instr[12] ? in_m : a_q;
        if (instr[11]) alu_x = 16'h0000;
        if (instr[10]) alu_x = ~alu_x;
        if (instr[9])  alu_y = 16'h0000;
        if (instr[8])  alu_y = ~alu_y;
        alu_o = instr[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (instr[6])  alu_o = ~alu_o;
        zr      = (alu_o == 16'h0000);
        ng      = alu_o[15];
        write_m = is_c && instr[3];
        jump    = is_c && ((instr[2] && ng) || (instr[1] && zr) || (instr[0] && !ng && !zr));
        a_d     = a_q;
        d_d     = d_q;
        if (!is_c)         a_d = instr;
        else if (instr[5]) a_d = alu_o;
        if (is_c && instr[4]) d_d = alu_o;
        pc_d = jump ? addr_m : (pc_q + 15'd1);
    end

    // Core is held in reset outside RUN, so every run begins at pc 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= '0;
        end else if (cpu_rst) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= '0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    // ---------------- run control ----------------
    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        halt_pc_d = halt_pc_q;
        cyc_d     = cyc_q;
        clr_d     = clr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                // stop is meaningless here but still suppresses a coincident start
                if (bus.start && !bus.stop) begin
                    state_d  = CLEAR_ON_START ? S_CLEAR : S_RUN;
                    cyc_d    = '0;
                    halted_d = 1'b0;
                    clr_d    = '0;
                end
            end
            S_CLEAR: begin
                if (bus.stop) begin
                    state_d  = S_IDLE;
                    halted_d = 1'b0;
                    clr_d    = '0;
                end else if (clr_q == '1) begin
                    state_d = S_RUN;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + DMEM_AW'(1);
                end
            end
            S_RUN: begin
                // The current cycle counts even when it ends the run.
                if (cyc_q != '1) cyc_d = cyc_q + CYCLE_W'(1);
                if (bus.stop) begin
                    state_d  = S_IDLE;
                    halted_d = 1'b0;
                end else if (halt_hit) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    halt_pc_d = pc_q[IMEM_AW-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            halted_q  <= 1'b0;
            halt_pc_q <= '0;
            cyc_q     <= '0;
            clr_q     <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            halt_pc_q <= halt_pc_d;
            cyc_q     <= cyc_d;
            clr_q     <= clr_d;
        end
    end

    // ---------------- memories (contents survive reset) ----------------
    always_ff @(posedge clock) begin
        if (load_fire) imem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clock) begin
        if (state_q == S_CLEAR)
            dmem[clr_q] <= 16'h0000;
        else if ((state_q == S_RUN) && write_m && dm_in_range)
            dmem[dm_idx] <= alu_o;
    end
endmodule
